// File: rtl/lighthouse_pkg.sv
// Shared definitions for the lighthouse sensor block: word widths and the
// frame scheduler state encoding.
package lighthouse_pkg;

    localparam int SENSOR_WORD_WIDTH = 32;
    localparam int DROP_COUNT_WIDTH  = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } frame_state_t;

endpackage

// File: rtl/lighthouse_frame_scheduler_if.sv
// Valid/ready stream carrying one captured sensor word plus its channel id
// from the frame scheduler to the SPI/host link.
interface lighthouse_frame_scheduler_if #(
    parameter int ID_WIDTH = 5
);
    import lighthouse_pkg::*;

    logic [SENSOR_WORD_WIDTH-1:0] frame_data_o;
    logic [ID_WIDTH-1:0]          frame_id_o;
    logic                         frame_valid_o;
    logic                         frame_ready_i;

    modport master (
        output frame_data_o,
        output frame_id_o,
        output frame_valid_o,
        input  frame_ready_i
    );

    modport slave (
        input  frame_data_o,
        input  frame_id_o,
        input  frame_valid_o,
        output frame_ready_i
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. The request vector is duplicated side by
// side, and the copy in the low half has every request below the pointer
// masked off. The lowest set bit of that double-width vector is therefore the
// first request at or after the pointer, wrapping around the channel count.
module rr_arbiter #(
    parameter int N  = 20,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [N-1:0]   w_low_mask;
    logic [2*N-1:0] w_double;
    logic           w_found;

    // Mark every channel strictly below the pointer so it is skipped in the first pass
    always_comb begin
        w_low_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_low_mask[i] = (i < int'(i_ptr));
        end
    end

    assign w_double = {i_req, i_req & ~w_low_mask};
    assign o_any    = |i_req;

    // Priority-encode the lowest set bit and fold it back into a channel index
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int j = 0; j < 2 * N; j++) begin
            if (!w_found && w_double[j]) begin
                automatic int k = (j >= N) ? (j - N) : j;
                w_found    = 1'b1;
                o_idx      = IW'(k);
                o_grant[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lighthouse_frame_scheduler.sv
// Shares one 32-bit stream between all lighthouse sensor channels. A channel
// becomes pending when its input word changes. Pending channels are granted
// round-robin, one word per IDLE/SEND pair. An update that lands on a channel
// that is still pending is counted as an overrun, and the newest word is kept.
module lighthouse_frame_scheduler
    import lighthouse_pkg::*;
#(
    parameter int NUMBER_OF_SENSORS = 20,
    parameter int ID_WIDTH          = (NUMBER_OF_SENSORS > 1) ? $clog2(NUMBER_OF_SENSORS) : 1
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic                                           enable_i,
    input  logic [SENSOR_WORD_WIDTH*NUMBER_OF_SENSORS-1:0] sensor_data_i,
    lighthouse_frame_scheduler_if.master                   frame_if,
    output logic [NUMBER_OF_SENSORS-1:0]                   pending_o,
    output logic [NUMBER_OF_SENSORS-1:0]                   overrun_o,
    output logic [DROP_COUNT_WIDTH-1:0]                    drop_count_o
);

    localparam int N = NUMBER_OF_SENSORS;

    typedef logic [DROP_COUNT_WIDTH:0] drop_sum_t;
    typedef logic [6:0]                overrun_cnt_t;

    frame_state_t                 r_state;
    frame_state_t                 w_state_next;
    logic [ID_WIDTH-1:0]          r_ptr;
    logic [ID_WIDTH-1:0]          r_frame_id;
    logic [SENSOR_WORD_WIDTH-1:0] r_frame_data;
    logic [DROP_COUNT_WIDTH-1:0]  r_drop_count;

    logic [N-1:0]                 r_pending;
    logic [N-1:0]                 r_overrun;
    logic [SENSOR_WORD_WIDTH-1:0] w_shadow [N];
    logic [N-1:0]                 w_change;
    logic [N-1:0]                 w_clear;
    logic [N-1:0]                 w_overrun_event;

    logic [N-1:0]                 w_grant_onehot;
    logic [ID_WIDTH-1:0]          w_grant_idx;
    logic                         w_grant_any;
    logic                         w_grant_fire;
    logic                         w_accept;
    overrun_cnt_t                 w_overrun_cnt;
    drop_sum_t                    w_drop_sum;

    rr_arbiter #(
        .N  (N),
        .IW (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req   (r_pending),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_onehot),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // The granted channel's pending flag drops in the grant cycle unless a new word arrives
    assign w_clear = w_grant_fire ? w_grant_onehot : '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_channel
        logic [SENSOR_WORD_WIDTH-1:0] r_last;
        logic [SENSOR_WORD_WIDTH-1:0] r_shadow;
        logic                         r_pend;
        logic                         r_ovr;
        logic [SENSOR_WORD_WIDTH-1:0] w_word;

        assign w_word              = sensor_data_i[gi*SENSOR_WORD_WIDTH +: SENSOR_WORD_WIDTH];
        assign w_change[gi]        = (w_word != r_last);
        assign w_overrun_event[gi] = w_change[gi] & r_pend & ~w_clear[gi];
        assign w_shadow[gi]        = r_shadow;
        assign r_pending[gi]       = r_pend;
        assign r_overrun[gi]       = r_ovr;

        // Capture changed words; a change in the grant cycle wins over the clear
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_last   <= '0;
                r_shadow <= '0;
                r_pend   <= 1'b0;
                r_ovr    <= 1'b0;
            end else begin
                if (w_change[gi]) begin
                    r_last   <= w_word;
                    r_shadow <= w_word;
                    r_pend   <= 1'b1;
                end else if (w_clear[gi]) begin
                    r_pend   <= 1'b0;
                end
                if (w_overrun_event[gi]) begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

    // Hold the current scheduler state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant from IDLE when enabled, return from SEND once the consumer takes the word
    always_comb begin
        w_state_next = r_state;
        w_grant_fire = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable_i && w_grant_any) begin
                    w_grant_fire = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (frame_if.frame_ready_i) begin
                    w_accept     = 1'b1;
                    w_state_next = IDLE;
                end
            end
        endcase
    end

    // Latch the granted word and id, and advance the pointer past the accepted channel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_data <= '0;
            r_frame_id   <= '0;
            r_ptr        <= '0;
        end else begin
            if (w_grant_fire) begin
                r_frame_data <= w_shadow[w_grant_idx];
                r_frame_id   <= w_grant_idx;
            end
            if (w_accept) begin
                r_ptr <= (r_frame_id == ID_WIDTH'(N - 1)) ? '0 : r_frame_id + ID_WIDTH'(1);
            end
        end
    end

    // Several channels can overrun in the same cycle, so count them all
    always_comb begin
        w_overrun_cnt = '0;
        for (int i = 0; i < N; i++) begin
            w_overrun_cnt = w_overrun_cnt + overrun_cnt_t'(w_overrun_event[i]);
        end
        w_drop_sum = drop_sum_t'(r_drop_count) + drop_sum_t'(w_overrun_cnt);
    end

    // Saturating total of overruns, cleared only by reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop_sum[DROP_COUNT_WIDTH]) begin
            r_drop_count <= '1;
        end else begin
            r_drop_count <= w_drop_sum[DROP_COUNT_WIDTH-1:0];
        end
    end

    assign frame_if.frame_valid_o = (r_state == SEND);
    assign frame_if.frame_data_o  = r_frame_data;
    assign frame_if.frame_id_o    = r_frame_id;
    assign pending_o              = r_pending;
    assign overrun_o              = r_overrun;
    assign drop_count_o           = r_drop_count;

endmodule

// File: tb/tb_lighthouse_frame_scheduler.sv
// Directed bench for the lighthouse frame scheduler with 20 channels.
module tb_lighthouse_frame_scheduler;

    logic         clock;
    logic         reset_n;
    logic         enable_i;
    logic [639:0] sensor_data;
    logic [19:0]  pending_o;
    logic [19:0]  overrun_o;
    logic [15:0]  drop_count_o;

    int checks_total;
    int checks_passed;

    lighthouse_frame_scheduler_if #(.ID_WIDTH(5)) frame_if ();

    lighthouse_frame_scheduler #(
        .NUMBER_OF_SENSORS (20),
        .ID_WIDTH          (5)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable_i      (enable_i),
        .sensor_data_i (sensor_data),
        .frame_if      (frame_if),
        .pending_o     (pending_o),
        .overrun_o     (overrun_o),
        .drop_count_o  (drop_count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [31:0] v);
        sensor_data[ch*32 +: 32] = v;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        sensor_data = '0;
        enable_i    = 1'b1;
        frame_if.frame_ready_i = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        sensor_data = '0;
        enable_i    = 1'b1;
        frame_if.frame_ready_i = 1'b1;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
        checks_total++; if (frame_if.frame_data_o !== 32'h0) $display("[TB] FAIL reset_data: got %0h expected 0", frame_if.frame_data_o); else checks_passed++;
        checks_total++; if (frame_if.frame_id_o !== 5'd0) $display("[TB] FAIL reset_id: got %0d expected 0", frame_if.frame_id_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h0) $display("[TB] FAIL reset_pending: got %0h expected 0", pending_o); else checks_passed++;
        checks_total++; if (overrun_o !== 20'h0) $display("[TB] FAIL reset_overrun: got %0h expected 0", overrun_o); else checks_passed++;
        checks_total++; if (drop_count_o !== 16'h0) $display("[TB] FAIL reset_drop: got %0h expected 0", drop_count_o); else checks_passed++;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_word(5, 32'h1234_5678);
        tick();
        checks_total++; if (pending_o !== 20'h00020) $display("[TB] FAIL single_pending_set: got %0h expected 20", pending_o); else checks_passed++;
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL single_valid_early: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL single_valid: got %0h expected 1", frame_if.frame_valid_o); else checks_passed++;
        checks_total++; if (frame_if.frame_id_o !== 5'd5) $display("[TB] FAIL single_id: got %0d expected 5", frame_if.frame_id_o); else checks_passed++;
        checks_total++; if (frame_if.frame_data_o !== 32'h1234_5678) $display("[TB] FAIL single_data: got %0h expected 12345678", frame_if.frame_data_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h0) $display("[TB] FAIL single_pending_clr: got %0h expected 0", pending_o); else checks_passed++;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL single_valid_drop: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_word(3, 32'h0000_00A3);
        set_word(17, 32'h0000_0B17);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd3 || frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL b2b_first_id: got id %0d valid %0h expected id 3 valid 1", frame_if.frame_id_o, frame_if.frame_valid_o); else checks_passed++;
        checks_total++; if (frame_if.frame_data_o !== 32'hA3) $display("[TB] FAIL b2b_first_data: got %0h expected a3", frame_if.frame_data_o); else checks_passed++;
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd17 || frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL b2b_second_id: got id %0d valid %0h expected id 17 valid 1", frame_if.frame_id_o, frame_if.frame_valid_o); else checks_passed++;
        checks_total++; if (frame_if.frame_data_o !== 32'hB17) $display("[TB] FAIL b2b_second_data: got %0h expected b17", frame_if.frame_data_o); else checks_passed++;
        tick();

        do_reset();
        set_word(3, 32'h0000_00C3);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd3) $display("[TB] FAIL b2b_prime_id: got %0d expected 3", frame_if.frame_id_o); else checks_passed++;
        tick();
        set_word(3, 32'h0000_00D3);
        set_word(17, 32'h0000_0E17);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd17 || frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL b2b_ptr4_first: got id %0d valid %0h expected id 17 valid 1", frame_if.frame_id_o, frame_if.frame_valid_o); else checks_passed++;
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd3 || frame_if.frame_data_o !== 32'hD3) $display("[TB] FAIL b2b_ptr4_second: got id %0d data %0h expected id 3 data d3", frame_if.frame_id_o, frame_if.frame_data_o); else checks_passed++;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        set_word(18, 32'h0000_0118);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd18) $display("[TB] FAIL wrap_prime_id: got %0d expected 18", frame_if.frame_id_o); else checks_passed++;
        tick();
        set_word(0, 32'h0000_0100);
        set_word(19, 32'h0000_0119);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd19 || frame_if.frame_data_o !== 32'h119) $display("[TB] FAIL wrap_id19: got id %0d data %0h expected id 19 data 119", frame_if.frame_id_o, frame_if.frame_data_o); else checks_passed++;
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd0 || frame_if.frame_data_o !== 32'h100 || frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL wrap_id0: got id %0d data %0h valid %0h expected id 0 data 100 valid 1", frame_if.frame_id_o, frame_if.frame_data_o, frame_if.frame_valid_o); else checks_passed++;
        tick();
    endtask

    task automatic test_backpressure();
        int stable_err;
        stable_err = 0;
        do_reset();
        frame_if.frame_ready_i = 1'b0;
        set_word(2, 32'h0000_0022);
        tick();
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd2 || frame_if.frame_valid_o !== 1'b1) $display("[TB] FAIL bp_grant: got id %0d valid %0h expected id 2 valid 1", frame_if.frame_id_o, frame_if.frame_valid_o); else checks_passed++;
        for (int c = 0; c < 50; c++) begin
            if (c == 10) set_word(7, 32'h0000_00A7);
            if (c == 20) set_word(7, 32'h0000_00B7);
            tick();
            if (frame_if.frame_valid_o !== 1'b1 || frame_if.frame_id_o !== 5'd2 || frame_if.frame_data_o !== 32'h22) stable_err++;
        end
        checks_total++; if (stable_err !== 0) $display("[TB] FAIL bp_stable: got %0d unstable cycles expected 0", stable_err); else checks_passed++;
        checks_total++; if (overrun_o !== 20'h00080) $display("[TB] FAIL bp_overrun: got %0h expected 80", overrun_o); else checks_passed++;
        checks_total++; if (drop_count_o !== 16'd1) $display("[TB] FAIL bp_drop: got %0d expected 1", drop_count_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h00080) $display("[TB] FAIL bp_pending: got %0h expected 80", pending_o); else checks_passed++;
        frame_if.frame_ready_i = 1'b1;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL bp_accept: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd7 || frame_if.frame_data_o !== 32'hB7) $display("[TB] FAIL bp_newest: got id %0d data %0h expected id 7 data b7", frame_if.frame_id_o, frame_if.frame_data_o); else checks_passed++;
        tick();
    endtask

    task automatic test_change_on_grant();
        do_reset();
        set_word(1, 32'h0000_0011);
        tick();
        set_word(1, 32'h0000_0022);
        tick();
        checks_total++; if (frame_if.frame_id_o !== 5'd1 || frame_if.frame_data_o !== 32'h11) $display("[TB] FAIL cog_old_word: got id %0d data %0h expected id 1 data 11", frame_if.frame_id_o, frame_if.frame_data_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h00002) $display("[TB] FAIL cog_pending: got %0h expected 2", pending_o); else checks_passed++;
        checks_total++; if (overrun_o !== 20'h0) $display("[TB] FAIL cog_overrun: got %0h expected 0", overrun_o); else checks_passed++;
        tick();
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b1 || frame_if.frame_data_o !== 32'h22) $display("[TB] FAIL cog_new_word: got valid %0h data %0h expected valid 1 data 22", frame_if.frame_valid_o, frame_if.frame_data_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h0 || drop_count_o !== 16'd0) $display("[TB] FAIL cog_final: got pending %0h drop %0d expected 0 0", pending_o, drop_count_o); else checks_passed++;
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        enable_i = 1'b0;
        set_word(8, 32'h0000_0088);
        repeat (3) tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b0 || pending_o !== 20'h00100) $display("[TB] FAIL en_hold: got valid %0h pending %0h expected 0 100", frame_if.frame_valid_o, pending_o); else checks_passed++;
        enable_i = 1'b1;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b1 || frame_if.frame_id_o !== 5'd8) $display("[TB] FAIL en_grant: got valid %0h id %0d expected 1 8", frame_if.frame_valid_o, frame_if.frame_id_o); else checks_passed++;
        enable_i = 1'b0;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL en_inflight: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
        enable_i = 1'b1;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        frame_if.frame_ready_i = 1'b0;
        set_word(4, 32'h0000_0044);
        tick();
        tick();
        set_word(9, 32'h0000_0009);
        tick();
        set_word(9, 32'h0000_0010);
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b1 || drop_count_o !== 16'd1) $display("[TB] FAIL rms_setup: got valid %0h drop %0d expected 1 1", frame_if.frame_valid_o, drop_count_o); else checks_passed++;
        #2;
        reset_n = 1'b0;
        sensor_data = '0;
        #1;
        checks_total++; if (frame_if.frame_valid_o !== 1'b0) $display("[TB] FAIL rms_valid: got %0h expected 0", frame_if.frame_valid_o); else checks_passed++;
        checks_total++; if (pending_o !== 20'h0 || overrun_o !== 20'h0 || drop_count_o !== 16'd0) $display("[TB] FAIL rms_flags: got pending %0h overrun %0h drop %0d expected 0 0 0", pending_o, overrun_o, drop_count_o); else checks_passed++;
        checks_total++; if (frame_if.frame_data_o !== 32'h0 || frame_if.frame_id_o !== 5'd0) $display("[TB] FAIL rms_out: got data %0h id %0d expected 0 0", frame_if.frame_data_o, frame_if.frame_id_o); else checks_passed++;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        frame_if.frame_ready_i = 1'b1;
        set_word(6, 32'h0000_0066);
        tick();
        checks_total++; if (pending_o !== 20'h00040) $display("[TB] FAIL rms_repost_pending: got %0h expected 40", pending_o); else checks_passed++;
        tick();
        checks_total++; if (frame_if.frame_valid_o !== 1'b1 || frame_if.frame_id_o !== 5'd6 || frame_if.frame_data_o !== 32'h66) $display("[TB] FAIL rms_repost: got valid %0h id %0d data %0h expected 1 6 66", frame_if.frame_valid_o, frame_if.frame_id_o, frame_if.frame_data_o); else checks_passed++;
        tick();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_change_on_grant();
        test_enable();
        test_reset_mid_send();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
